// File: rtl/bcd_time_counter_if.sv
// rtl/bcd_time_counter_if.sv - control and time-of-day bus between the front panel and bcd_time_counter
interface bcd_time_counter_if;
  logic       en;
  logic       adj_min;
  logic       adj_hour;
  logic [7:0] hour;
  logic [7:0] minute;
  logic [7:0] second;
  logic       min_tick;
  logic       hour_tick;
  logic       day_tick;
  logic       pm;

  modport master (
    output en, adj_min, adj_hour,
    input  hour, minute, second, min_tick, hour_tick, day_tick, pm
  );

  modport slave (
    input  en, adj_min, adj_hour,
    output hour, minute, second, min_tick, hour_tick, day_tick, pm
  );
endinterface

// File: rtl/bcd_time_counter.sv
// rtl/bcd_time_counter.sv - packed-BCD hh:mm:ss counter with rollover ticks and manual adjust (HOUR12_EN selects 12 h mode)
module bcd_time_counter #(
  parameter logic [7:0] RESET_HOUR   = 8'h00,
  parameter logic [7:0] RESET_MINUTE = 8'h00
) (
  input logic               clk_1hz,
  input logic               cr,
  bcd_time_counter_if.slave bus
);

  // Seconds and minutes share the same 00..59 BCD step.
  function automatic logic [7:0] inc60(input logic [7:0] v);
    if (v == 8'h59)          inc60 = 8'h00;
    else if (v[3:0] == 4'd9) inc60 = {v[7:4] + 4'd1, 4'd0};
    else                     inc60 = {v[7:4], v[3:0] + 4'd1};
  endfunction

`ifdef HOUR12_EN
  // 12 h sequence: 12, 01, 02 ... 11, 12.
  function automatic logic [7:0] inc_hour(input logic [7:0] v);
    if (v == 8'h12)          inc_hour = 8'h01;
    else if (v[3:0] == 4'd9) inc_hour = {v[7:4] + 4'd1, 4'd0};
    else                     inc_hour = {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Midnight is shown as 12 AM, so a zero reset hour means 12.
  localparam logic [7:0] RESET_HOUR_EFF = (RESET_HOUR == 8'h00) ? 8'h12 : RESET_HOUR;
`else
  // 24 h sequence: 00 .. 23, 00.
  function automatic logic [7:0] inc_hour(input logic [7:0] v);
    if (v == 8'h23)          inc_hour = 8'h00;
    else if (v[3:0] == 4'd9) inc_hour = {v[7:4] + 4'd1, 4'd0};
    else                     inc_hour = {v[7:4], v[3:0] + 4'd1};
  endfunction

  localparam logic [7:0] RESET_HOUR_EFF = RESET_HOUR;
`endif

  logic [7:0] hour_q, minute_q, second_q;
  logic       min_tick_q, hour_tick_q, day_tick_q, pm_q;

  logic [7:0] hour_n, minute_n, second_n;
  logic       pm_n, day_n;
  logic       sec_carry, min_carry, hour_step;

  // Next-state: natural carries and adjust requests merge into a single +1 per field.
  always_comb begin
    sec_carry = bus.en && (second_q == 8'h59);
    min_carry = sec_carry && (minute_q == 8'h59);
    hour_step = min_carry || bus.adj_hour;

    second_n  = bus.en ? inc60(second_q) : second_q;
    minute_n  = (sec_carry || bus.adj_min) ? inc60(minute_q) : minute_q;
    hour_n    = hour_step ? inc_hour(hour_q) : hour_q;

`ifdef HOUR12_EN
    // Any 11 -> 12 step flips the half-day; only the natural PM -> AM one ends the day.
    pm_n      = pm_q ^ (hour_step && (hour_q == 8'h11));
    day_n     = min_carry && (hour_q == 8'h11) && pm_q;
`else
    pm_n      = 1'b0;
    day_n     = min_carry && (hour_q == 8'h23);
`endif
  end

  // Time and tick registers; cr overrides everything and drops any pending carry.
  always_ff @(posedge clk_1hz) begin
    if (cr) begin
      hour_q      <= RESET_HOUR_EFF;
      minute_q    <= RESET_MINUTE;
      second_q    <= 8'h00;
      min_tick_q  <= 1'b0;
      hour_tick_q <= 1'b0;
      day_tick_q  <= 1'b0;
      pm_q        <= 1'b0;
    end else begin
      hour_q      <= hour_n;
      minute_q    <= minute_n;
      second_q    <= second_n;
      min_tick_q  <= sec_carry;
      hour_tick_q <= min_carry;
      day_tick_q  <= day_n;
      pm_q        <= pm_n;
    end
  end

  assign bus.hour      = hour_q;
  assign bus.minute    = minute_q;
  assign bus.second    = second_q;
  assign bus.min_tick  = min_tick_q;
  assign bus.hour_tick = hour_tick_q;
  assign bus.day_tick  = day_tick_q;
  assign bus.pm        = pm_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// tb/tb_bcd_time_counter.sv - directed self-checking bench for bcd_time_counter
module tb_bcd_time_counter;

`ifdef HOUR12_EN
  localparam logic [7:0] RH = 8'h11;
`else
  localparam logic [7:0] RH = 8'h13;
`endif

  logic clk_1hz;
  logic cr;
  int   checks;
  int   errors;
  int   mt_cnt;
  int   ht_cnt;
  int   dt_cnt;

  bcd_time_counter_if bus ();

  bcd_time_counter #(
    .RESET_HOUR  (RH),
    .RESET_MINUTE(8'h00)
  ) dut (
    .clk_1hz(clk_1hz),
    .cr     (cr),
    .bus    (bus)
  );

  initial begin
    clk_1hz = 1'b0;
    forever #5 clk_1hz = ~clk_1hz;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    mt_cnt = 0;
    ht_cnt = 0;
    dt_cnt = 0;
  endtask

  // Advance n edges, sampling 1 ns after each edge and tallying ticks.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_1hz);
      #1;
      mt_cnt += int'(bus.min_tick);
      ht_cnt += int'(bus.hour_tick);
      dt_cnt += int'(bus.day_tick);
    end
  endtask

  task automatic chk_time(input string tag, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    chk({tag, ".hour"}, bus.hour, h);
    chk({tag, ".minute"}, bus.minute, m);
    chk({tag, ".second"}, bus.second, s);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr();
    cr = 1'b1;
    bus.en = 1'b0;
    bus.adj_min = 1'b0;
    bus.adj_hour = 1'b0;

    run(2);
    chk_time("reset", RH, 8'h00, 8'h00);
    chk("reset.ticks", 8'(mt_cnt + ht_cnt + dt_cnt), 8'd0);
    chk("reset.pm", {7'd0, bus.pm}, 8'd0);
    cr = 1'b0;

`ifdef HOUR12_EN
    bus.adj_min = 1'b1; run(59); bus.adj_min = 1'b0;
    bus.en = 1'b1; run(59);
    chk_time("am_pre", 8'h11, 8'h59, 8'h59);
    clr();
    run(1);
    chk_time("noon", 8'h12, 8'h00, 8'h00);
    chk("noon.pm", {7'd0, bus.pm}, 8'd1);
    chk("noon.hour_tick", {7'd0, bus.hour_tick}, 8'd1);
    chk("noon.day_tick", {7'd0, bus.day_tick}, 8'd0);
    bus.en = 1'b0;
    bus.adj_hour = 1'b1; run(11); bus.adj_hour = 1'b0;
    chk("pm_adj.hour", bus.hour, 8'h11);
    chk("pm_adj.pm", {7'd0, bus.pm}, 8'd1);
    bus.adj_min = 1'b1; run(59); bus.adj_min = 1'b0;
    bus.en = 1'b1; run(59);
    chk_time("pm_pre", 8'h11, 8'h59, 8'h59);
    clr();
    run(1);
    chk_time("midnight", 8'h12, 8'h00, 8'h00);
    chk("midnight.pm", {7'd0, bus.pm}, 8'd0);
    chk("midnight.hour_tick", {7'd0, bus.hour_tick}, 8'd1);
    chk("midnight.day_tick", {7'd0, bus.day_tick}, 8'd1);
`else
    // First minute of counting from 13:00:00.
    bus.en = 1'b1;
    clr();
    run(59);
    chk("count59.second", bus.second, 8'h59);
    chk("count59.min_ticks", 8'(mt_cnt), 8'd0);
    run(1);
    chk_time("count60", 8'h13, 8'h01, 8'h00);
    chk("count60.min_tick", {7'd0, bus.min_tick}, 8'd1);
    chk("count60.min_ticks", 8'(mt_cnt), 8'd1);

    // Preset 23:59:50 and cross midnight.
    bus.en = 1'b0;
    clr();
    bus.adj_min = 1'b1; run(58); bus.adj_min = 1'b0;
    bus.adj_hour = 1'b1; run(10); bus.adj_hour = 1'b0;
    bus.en = 1'b1; run(50);
    chk_time("preset", 8'h23, 8'h59, 8'h50);
    chk("preset.ticks", 8'(mt_cnt + ht_cnt + dt_cnt), 8'd0);
    run(9);
    chk("pre_wrap.second", bus.second, 8'h59);
    run(1);
    chk_time("day_wrap", 8'h00, 8'h00, 8'h00);
    chk("day_wrap.min_tick", {7'd0, bus.min_tick}, 8'd1);
    chk("day_wrap.hour_tick", {7'd0, bus.hour_tick}, 8'd1);
    chk("day_wrap.day_tick", {7'd0, bus.day_tick}, 8'd1);
    clr();
    run(1);
    chk_time("post_wrap", 8'h00, 8'h00, 8'h01);
    chk("post_wrap.ticks", 8'(mt_cnt + ht_cnt + dt_cnt), 8'd0);

    // Adjust while frozen: minute 00 + 61 wraps to 01, no hour carry.
    bus.en = 1'b0;
    clr();
    bus.adj_min = 1'b1; run(61); bus.adj_min = 1'b0;
    chk_time("adj_min61", 8'h00, 8'h01, 8'h01);
    chk("adj_min61.ticks", 8'(mt_cnt + ht_cnt + dt_cnt), 8'd0);
    bus.adj_hour = 1'b1; run(21);
    chk("adj_hour21.hour", bus.hour, 8'h21);
    run(25); bus.adj_hour = 1'b0;
    chk_time("adj_hour25", 8'h22, 8'h01, 8'h01);
    chk("adj_hour25.ticks", 8'(mt_cnt + ht_cnt + dt_cnt), 8'd0);

    // Collision at 10:59:59: carry and adjusts give one step each.
    bus.adj_hour = 1'b1; run(12); bus.adj_hour = 1'b0;
    bus.adj_min = 1'b1; run(58); bus.adj_min = 1'b0;
    bus.en = 1'b1; run(58);
    chk_time("coll_pre", 8'h10, 8'h59, 8'h59);
    bus.adj_min = 1'b1;
    bus.adj_hour = 1'b1;
    run(1);
    bus.adj_min = 1'b0;
    bus.adj_hour = 1'b0;
    chk_time("collision", 8'h11, 8'h00, 8'h00);
    chk("collision.min_tick", {7'd0, bus.min_tick}, 8'd1);
    chk("collision.hour_tick", {7'd0, bus.hour_tick}, 8'd1);
    chk("collision.day_tick", {7'd0, bus.day_tick}, 8'd0);

    // Reset on the 09:59:59 carry edge.
    bus.en = 1'b0;
    bus.adj_hour = 1'b1; run(22); bus.adj_hour = 1'b0;
    bus.adj_min = 1'b1; run(59); bus.adj_min = 1'b0;
    bus.en = 1'b1; run(59);
    chk_time("rst_pre", 8'h09, 8'h59, 8'h59);
    clr();
    cr = 1'b1;
    run(1);
    chk_time("rst_mid", RH, 8'h00, 8'h00);
    chk("rst_mid.ticks", 8'(mt_cnt + ht_cnt + dt_cnt), 8'd0);
    cr = 1'b0;
    run(1);
    chk_time("rst_after", RH, 8'h00, 8'h01);
    chk("rst_after.ticks", 8'(mt_cnt + ht_cnt + dt_cnt), 8'd0);
    chk("rst_after.pm", {7'd0, bus.pm}, 8'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
